round_timer: RTL and testbench
==============================

# round_timer

Countdown timer that consumes the per-round period produced by the score-to-speed lookup and enforces the player's response window in the memory game. On `start` it latches the current period, counts down one per clock, and reports either a timeout or a player answer, whichever comes first. The remaining count at answer time is exposed for scoring and display, and a warning flag drives the "hurry" LED during the last quarter of the window.

## Interface
- `WIDTH`, 28: width of the period and the down-counter; matches the speed lookup's period output.
- `clock`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `count_value`  input  WIDTH  round period in clock cycles, taken from the speed lookup; sampled only on an accepted `start`.
- `start`  input  1  single-cycle pulse that begins or restarts a round.
- `answer`  input  1  single-cycle pulse; the player has completed input for this round.
- `pause`  input  1  level; while high, the countdown holds.
- `busy`  output  1  high while a round is running.
- `timeout`  output  1  one-cycle pulse when the window expires.
- `answered`  output  1  one-cycle pulse when `answer` is accepted.
- `remaining`  output  WIDTH  current countdown value; held after the round ends.
- `warn`  output  1  high while `busy` and `remaining <= period >> 2`.

## Operation
- States: IDLE and RUN. `busy` is 1 exactly in RUN.
- Internal register `period` (WIDTH bits) holds the latched round length.
- IDLE:
  - `start=1`: `period <= max(count_value, 1)`, `remaining <= max(count_value, 1)`, go to RUN.
  - `answer` and `pause` are ignored.
- RUN, in priority order:
  1. `start=1`: reload `period` and `remaining` exactly as from IDLE and stay in RUN. No `timeout` or `answered` pulse is issued.
  2. `answer=1`: pulse `answered`, go to IDLE, and freeze `remaining` at its current, undecremented value. This applies even while `pause=1`.
  3. `pause=1`: hold `remaining`.
  4. Otherwise, `remaining <= remaining - 1`. If `remaining == 1`, `remaining` becomes 0, `timeout` pulses, and the state goes to IDLE.
- `answer` and the final decrement in the same cycle: `answer` wins. `answered` pulses, `remaining` stays 1, and there is no `timeout`.
- `timeout` and `answered` are never high together and are never high for more than one cycle.
- `warn` is combinational from registered state: `busy & (remaining <= (period >> 2))`. Comparison is unsigned at full WIDTH.
- All arithmetic is unsigned WIDTH-bit. `remaining` never wraps below 0 because the FSM leaves RUN on reaching 0.

## Timing
- Reset (async, `rst_n=0`) sets state IDLE, `period=0`, `remaining=0`, `busy=0`, `timeout=0`, `answered=0`, `warn=0`. Reset mid-round aborts the round with no pulse.
- Reset release is synchronous in effect; the first active edge after `rst_n` rises may accept `start`.
- `start` sampled at edge E: `busy=1` and `remaining=P` are visible after E.
- With no pause and no answer, `timeout` is high for the single cycle following edge E+P, `busy=0` in that same cycle, and `remaining=0`. The round therefore spans exactly P cycles of `busy`.
- Each cycle with `pause=1` in RUN extends the round by one cycle.
- `answer` sampled at edge A: `answered=1` and `busy=0` in the cycle after A; `remaining` holds the value it had before A.
- `count_value` changes while in RUN have no effect until the next `start`.

## Test plan
- Basic timeout: `count_value=5`, pulse `start` -> `busy` high for 5 cycles, `remaining` reads 5,4,3,2,1; then `timeout=1` for one cycle with `remaining=0`, `busy=0`; `warn=1` only when `remaining=1`.
- Early answer: `count_value=8`, `start`, then `answer` while `remaining=6` -> next cycle `answered=1`, `busy=0`, `remaining` stays 6 indefinitely; no `timeout`.
- Pause and collision: `count_value=4`, `start`, hold `pause` for 3 cycles at `remaining=3` -> `timeout` comes 3 cycles later than without pause. Separately, assert `answer` in the cycle `remaining=1` -> `answered` pulses, `remaining=1`, no `timeout`.
- Restart and zero period: `start` at `count_value=10`; at `remaining=7`, `start` again with `count_value=3` -> `remaining=3`, no pulses, timeout 3 cycles later. Then `start` with `count_value=0` -> `period=1`, `timeout` 1 cycle later.
- Reset mid-round and idle inputs: assert `rst_n=0` asynchronously at `remaining=20` -> all outputs 0 immediately. Pulse `answer` in IDLE -> no `answered`. Then `start` with `count_value=28'hFFFFFFF` -> `remaining` reads `28'hFFFFFFE` after one decrement; `warn=0`.

Source files
------------

// File: rtl/round_timer.sv
// Round response-window timer: latches the round period on start, counts down
// once per clock, and reports either a timeout or an accepted answer.
module round_timer #(
   parameter int WIDTH = 28
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] count_value,
   input  logic             start,
   input  logic             answer,
   input  logic             pause,
   output logic             busy,
   output logic             timeout,
   output logic             answered,
   output logic [WIDTH-1:0] remaining,
   output logic             warn
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

   // A zero period would time out before the player sees the round, so clamp to one.
   function automatic logic [WIDTH-1:0] clamp_period(input logic [WIDTH-1:0] value);
      logic [WIDTH-1:0] result;
      if (value == ZERO_C) begin
         result = ONE_C;
      end else begin
         result = value;
      end
      return result;
   endfunction

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] period_r;
   logic [WIDTH-1:0] period_s;
   logic [WIDTH-1:0] remaining_r;
   logic [WIDTH-1:0] remaining_s;
   logic             timeout_r;
   logic             timeout_s;
   logic             answered_r;
   logic             answered_s;
   logic             warn_r;
   logic             warn_s;
   logic [WIDTH-1:0] load_value_s;

   assign load_value_s = clamp_period(count_value);

   // Next-state, counter update and pulse generation; start beats answer beats pause.
   always_comb begin
      state_s     = state_r;
      period_s    = period_r;
      remaining_s = remaining_r;
      timeout_s   = 1'b0;
      answered_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               period_s    = load_value_s;
               remaining_s = load_value_s;
               state_s     = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (start) begin
               period_s    = load_value_s;
               remaining_s = load_value_s;
               state_s     = ST_RUN;
            end else if (answer) begin
               answered_s = 1'b1;
               state_s    = ST_IDLE;
            end else if (pause) begin
               remaining_s = remaining_r;
            end else begin
               remaining_s = remaining_r - ONE_C;
               if (remaining_r == ONE_C) begin
                  timeout_s = 1'b1;
                  state_s   = ST_IDLE;
               end else begin
                  state_s = ST_RUN;
               end
            end
         end
         default: begin
            state_s     = ST_IDLE;
            period_s    = ZERO_C;
            remaining_s = ZERO_C;
         end
      endcase
   end

   // Warn is computed from next-state values so the registered flag lines up with busy/remaining.
   always_comb begin
      warn_s = 1'b0;
      if (state_s == ST_RUN) begin
         warn_s = (remaining_s <= (period_s >> 1'b1 >> 1'b1));
      end else begin
         warn_s = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         period_r    <= ZERO_C;
         remaining_r <= ZERO_C;
         timeout_r   <= 1'b0;
         answered_r  <= 1'b0;
         warn_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         period_r    <= period_s;
         remaining_r <= remaining_s;
         timeout_r   <= timeout_s;
         answered_r  <= answered_s;
         warn_r      <= warn_s;
      end
   end

   assign busy      = (state_r == ST_RUN);
   assign timeout   = timeout_r;
   assign answered  = answered_r;
   assign remaining = remaining_r;
   assign warn      = warn_r;

endmodule

// File: tb/tb_round_timer.sv
// Table-driven bench for round_timer: each vector drives one clock of inputs and
// queues the outputs expected right after that edge.
module tb_round_timer;

   localparam int W = 28;

   logic         clock = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] count_value = '0;
   logic         start = 1'b0;
   logic         answer = 1'b0;
   logic         pause = 1'b0;
   logic         busy;
   logic         timeout;
   logic         answered;
   logic [W-1:0] remaining;
   logic         warn;

   typedef struct {
      logic         st;
      logic         an;
      logic         pa;
      logic [W-1:0] cv;
      logic         e_busy;
      logic         e_to;
      logic         e_ans;
      logic [W-1:0] e_rem;
      logic         e_warn;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   round_timer #(.WIDTH(W)) dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .count_value(count_value),
      .start      (start),
      .answer     (answer),
      .pause      (pause),
      .busy       (busy),
      .timeout    (timeout),
      .answered   (answered),
      .remaining  (remaining),
      .warn       (warn)
   );

   always #5 clock = ~clock;

   function automatic vec_t mk(input logic st, input logic an, input logic pa, input logic [W-1:0] cv,
                               input logic b, input logic t, input logic a, input logic [W-1:0] r,
                               input logic w);
      vec_t v;
      v.st = st; v.an = an; v.pa = pa; v.cv = cv;
      v.e_busy = b; v.e_to = t; v.e_ans = a; v.e_rem = r; v.e_warn = w;
      return v;
   endfunction

   task automatic add(input logic st, input logic an, input logic pa, input logic [W-1:0] cv,
                      input logic b, input logic t, input logic a, input logic [W-1:0] r,
                      input logic w);
      tbl.push_back(mk(st, an, pa, cv, b, t, a, r, w));
   endtask

   task automatic check_out(input string name);
      vec_t e;
      e = exp_q.pop_front();
      vectors++;
      if (busy !== e.e_busy || timeout !== e.e_to || answered !== e.e_ans ||
          remaining !== e.e_rem || warn !== e.e_warn) begin
         miscompares++;
         $display("FAIL %s: got busy=%b to=%b ans=%b rem=%h warn=%b, want busy=%b to=%b ans=%b rem=%h warn=%b",
                  name, busy, timeout, answered, remaining, warn,
                  e.e_busy, e.e_to, e.e_ans, e.e_rem, e.e_warn);
      end
   endtask

   task automatic apply(input vec_t v, input string name);
      @(negedge clock);
      start = v.st;
      answer = v.an;
      pause = v.pa;
      count_value = v.cv;
      exp_q.push_back(v);
      @(posedge clock);
      #1;
      check_out(name);
   endtask

   task automatic check_zero(input string name);
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0));
      check_out(name);
   endtask

   initial begin
      // basic timeout, period 5
      add(1,0,0,28'd5,  1,0,0,28'd5,0);
      add(0,0,0,28'd77, 1,0,0,28'd4,0);
      add(0,0,0,28'd0,  1,0,0,28'd3,0);
      add(0,0,0,28'd9,  1,0,0,28'd2,0);
      add(0,0,0,28'd1,  1,0,0,28'd1,1);
      add(0,0,0,28'd3,  0,1,0,28'd0,0);
      add(0,0,0,28'd3,  0,0,0,28'd0,0);
      // early answer, then answer/pause ignored in idle
      add(1,0,0,28'd8,  1,0,0,28'd8,0);
      add(0,0,0,28'd2,  1,0,0,28'd7,0);
      add(0,0,0,28'd2,  1,0,0,28'd6,0);
      add(0,1,0,28'd2,  0,0,1,28'd6,0);
      add(0,0,0,28'd2,  0,0,0,28'd6,0);
      add(0,1,1,28'd2,  0,0,0,28'd6,0);
      add(0,0,0,28'd2,  0,0,0,28'd6,0);
      // pause holds for three cycles at 3
      add(1,0,0,28'd4,  1,0,0,28'd4,0);
      add(0,0,0,28'd4,  1,0,0,28'd3,0);
      add(0,0,1,28'd4,  1,0,0,28'd3,0);
      add(0,0,1,28'd4,  1,0,0,28'd3,0);
      add(0,0,1,28'd4,  1,0,0,28'd3,0);
      add(0,0,0,28'd4,  1,0,0,28'd2,0);
      add(0,0,0,28'd4,  1,0,0,28'd1,1);
      add(0,0,0,28'd4,  0,1,0,28'd0,0);
      // answer collides with final decrement
      add(1,0,0,28'd4,  1,0,0,28'd4,0);
      add(0,0,0,28'd4,  1,0,0,28'd3,0);
      add(0,0,0,28'd4,  1,0,0,28'd2,0);
      add(0,0,0,28'd4,  1,0,0,28'd1,1);
      add(0,1,0,28'd4,  0,0,1,28'd1,0);
      add(0,0,0,28'd4,  0,0,0,28'd1,0);
      // answer while paused
      add(1,0,0,28'd4,  1,0,0,28'd4,0);
      add(0,1,1,28'd4,  0,0,1,28'd4,0);
      // restart mid-round, then zero period
      add(1,0,0,28'd10, 1,0,0,28'd10,0);
      add(0,0,0,28'd50, 1,0,0,28'd9,0);
      add(0,0,0,28'd50, 1,0,0,28'd8,0);
      add(0,0,0,28'd50, 1,0,0,28'd7,0);
      add(1,0,0,28'd3,  1,0,0,28'd3,0);
      add(0,0,0,28'd3,  1,0,0,28'd2,0);
      add(0,0,0,28'd3,  1,0,0,28'd1,0);
      add(0,0,0,28'd3,  0,1,0,28'd0,0);
      add(1,0,0,28'd0,  1,0,0,28'd1,0);
      add(0,0,0,28'd0,  0,1,0,28'd0,0);
      add(0,0,0,28'd0,  0,0,0,28'd0,0);
      // start outranks a simultaneous answer
      add(1,0,0,28'd6,  1,0,0,28'd6,0);
      add(1,1,0,28'd2,  1,0,0,28'd2,0);
      add(0,0,0,28'd2,  1,0,0,28'd1,0);
      add(0,0,0,28'd2,  0,1,0,28'd0,0);

      #12;
      check_zero("reset_state");
      @(negedge clock);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("vec%0d", i));
      end

      // reset mid-round at remaining=20
      apply(mk(1,0,0,28'd25, 1,0,0,28'd25,0), "rst_load");
      for (int k = 1; k <= 5; k++) begin
         apply(mk(0,0,0,28'd25, 1,0,0,28'd25 - W'(k),0), $sformatf("rst_dec%0d", k));
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("async_reset");
      @(posedge clock);
      #1;
      check_zero("reset_held");
      @(negedge clock);
      rst_n = 1'b1;
      apply(mk(0,1,0,28'd5, 0,0,0,28'd0,0), "idle_answer");
      apply(mk(1,0,0,28'hFFFFFFF, 1,0,0,28'hFFFFFFF,0), "max_load");
      apply(mk(0,0,0,28'd0, 1,0,0,28'hFFFFFFE,0), "max_dec");

      @(negedge clock);
      start = 1'b0;
      answer = 1'b0;
      pause = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
